hdlc_command_decode: RTL and testbench
======================================

Name: hdlc_command_decode

Overview:
- Sits directly downstream of the HDLC serial command receiver.
- Consumes its byte stream (tvalid/tlast/tdata, no back-pressure) and assembles 6-byte command frames.
- Checks each frame's header, length and checksum. Delivers good commands as a single-cycle pulse with decoded ID and 24-bit parameter.
- Reports errors and keeps good/bad frame counters for status readback.

Parameters:
- HEADER, 8'h55, required value of byte 0 of every frame.
- TIMEOUT_CYC, 20000, maximum clk cycles between accepted bytes inside a frame before abort; legal range 2..65535.

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- s_tvalid  input  1  byte strobe from receiver, one-cycle pulses
- s_tlast  input  1  last byte of frame, qualified by s_tvalid
- s_tdata  input  8  byte value, qualified by s_tvalid
- cnt_clr  input  1  synchronous clear of both frame counters
- cmd_valid  output  1  one-cycle pulse: new good command
- cmd_id  output  8  command ID (frame byte 1), held until next good command
- cmd_param  output  24  parameter {byte2,byte3,byte4}, held until next good command
- err_valid  output  1  one-cycle pulse: frame rejected
- err_code  output  2  0 header, 1 length, 2 checksum, 3 timeout; valid with err_valid, held after
- ok_cnt  output  16  count of good frames, saturating
- err_cnt  output  16  count of rejected frames, saturating

Behaviour:
- Reset: asynchronous, active-low on rstn. All outputs clear to 0. FSM goes to IDLE. Byte index, timer and shadow registers clear.
- Frame format: byte0 = HEADER, byte1 = ID, byte2..4 = param MSB first, byte5 = checksum, with s_tlast only on byte5. Checksum is the 8-bit modulo-256 sum of bytes 1..4.
- A byte is accepted on any cycle with s_tvalid=1. There is no ready signal, so every strobe must be consumed.

FSM states:
- IDLE
  - byte == HEADER with s_tlast=0 -> COLLECT, index=1, running sum cleared.
  - byte == HEADER with s_tlast=1 -> error code 1, stay IDLE.
  - byte != HEADER -> error code 0, stay IDLE. Each mismatching byte is one error.
- COLLECT
  - Bytes 1..4 are shifted into shadow registers and added to the running sum.
  - s_tlast on any of these bytes -> error 1, IDLE.
  - After byte 4 -> CHECK.
- CHECK
  - The next byte is compared with the sum; s_tlast must be 1.
  - s_tlast=0 -> error 1.
  - Mismatch -> error 2.
  - Otherwise good frame.
  - All three outcomes return to IDLE.

Outputs and counters:
- Good frame: on the cycle after the checksum byte, cmd_valid=1 and cmd_id/cmd_param update from the shadow registers; ok_cnt increments.
- Error: on the cycle after the offending byte or timeout, err_valid=1 and err_code is set; err_cnt increments. Shadow registers are discarded; cmd_id/cmd_param keep their old values.
- cmd_valid and err_valid are never high together.
- Counters saturate at 16'hFFFF.
- If cnt_clr coincides with an increment, the counter becomes 0 (clear wins).

Timeout:
- The timer runs in COLLECT/CHECK and is reset on every accepted byte.
- Reaching TIMEOUT_CYC -> error 3, IDLE.
- If a byte arrives on the same cycle the timeout would fire, the byte wins: it is processed and the timer resets.
- The timer is idle and held at 0 in IDLE.

Other rules:
- Back-to-back frames with zero gap are supported.
- The cycle after a frame ends in IDLE can accept a new header.
- Reset mid-frame discards the partial frame with no pulse.

Optional Feature:
- Macro: CMD_CRC8_EN.
- Defined: byte5 is checked against CRC-8, polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, over bytes 1..4 MSB-first. The CRC is updated one byte per accepted strobe with no added latency.
- Undefined: modulo-256 sum as above; no CRC logic is synthesised.

Test Plan:
- Good frame: bytes 55 01 12 34 56 9D, tlast on 9D -> one cmd_valid one cycle after 9D; cmd_id=01, cmd_param=123456, ok_cnt=1, no err_valid.
- Checksum error: bytes 55 01 12 34 56 9E -> err_valid with err_code=2, err_cnt=1; cmd_id/cmd_param unchanged.
- Length errors: 55 01 12 with tlast on 12 -> err_code=1. Then 55 01 12 34 56 9D with tlast=0 on 9D -> err_code=1. err_cnt=2, FSM back in IDLE.
- Header error and recovery: bytes AA 55 02 00 00 01 03 -> one err_code=0 for AA, then a good command with ID=02, param=000001.
- Timeout (TIMEOUT_CYC=100): 55 01 then a 100-cycle gap -> err_code=3. A byte arriving exactly at cycle 100 instead -> no error, frame continues.
- Counters: preload err_cnt to FFFF via errors, inject another error -> stays FFFF. Pulse cnt_clr together with a good frame's increment -> ok_cnt=0.

Source files
------------

// File: rtl/hdlc_command_decode.sv
// Assembles 6-byte HDLC command frames, validates header/length/check byte and timeout.
// Define CMD_CRC8_EN to check byte 5 as a CRC-8 (poly 0x07) instead of the modulo-256 sum.
module hdlc_command_decode #(
    parameter logic [7:0] HEADER      = 8'h55,
    parameter int         TIMEOUT_CYC = 20000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    input  logic [7:0]  s_tdata,
    input  logic        cnt_clr,
    output logic        cmd_valid,
    output logic [7:0]  cmd_id,
    output logic [23:0] cmd_param,
    output logic        err_valid,
    output logic [1:0]  err_code,
    output logic [15:0] ok_cnt,
    output logic [15:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, COLLECT, CHECK} state_t;

    localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      state, state_nxt;
    logic [1:0]  idx, idx_nxt;
    logic [7:0]  sum, sum_nxt, chk_upd;
    logic [31:0] shadow, shadow_nxt;
    logic [15:0] timer, timer_nxt;
    logic        ok_evt, err_evt;
    logic [1:0]  code_nxt;

`ifdef CMD_CRC8_EN
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++)
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        return c;
    endfunction

    assign chk_upd = crc8_step(sum, s_tdata);
`else
    assign chk_upd = sum + s_tdata;
`endif

    // idx counts payload bytes 1..4 as 0..3; the timer counts idle cycles since the last byte
    always_comb begin
        state_nxt  = state;
        idx_nxt    = idx;
        sum_nxt    = sum;
        shadow_nxt = shadow;
        timer_nxt  = timer;
        ok_evt     = 1'b0;
        err_evt    = 1'b0;
        code_nxt   = 2'd0;
        case (state)
            IDLE: begin
                timer_nxt = '0;
                if (s_tvalid) begin
                    if (s_tdata != HEADER) begin
                        err_evt  = 1'b1;
                        code_nxt = 2'd0;
                    end else if (s_tlast) begin
                        err_evt  = 1'b1;
                        code_nxt = 2'd1;
                    end else begin
                        state_nxt = COLLECT;
                        idx_nxt   = '0;
                        sum_nxt   = '0;
                    end
                end
            end
            COLLECT: begin
                if (s_tvalid) begin
                    timer_nxt  = '0;
                    shadow_nxt = {shadow[23:0], s_tdata};
                    sum_nxt    = chk_upd;
                    if (s_tlast) begin
                        err_evt   = 1'b1;
                        code_nxt  = 2'd1;
                        state_nxt = IDLE;
                    end else if (idx == 2'd3) begin
                        state_nxt = CHECK;
                    end else begin
                        idx_nxt = idx + 2'd1;
                    end
                end else if (timer == TIMER_LAST) begin
                    err_evt   = 1'b1;
                    code_nxt  = 2'd3;
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            CHECK: begin
                if (s_tvalid) begin
                    timer_nxt = '0;
                    state_nxt = IDLE;
                    if (!s_tlast) begin
                        err_evt  = 1'b1;
                        code_nxt = 2'd1;
                    end else if (s_tdata != sum) begin
                        err_evt  = 1'b1;
                        code_nxt = 2'd2;
                    end else begin
                        ok_evt = 1'b1;
                    end
                end else if (timer == TIMER_LAST) begin
                    err_evt   = 1'b1;
                    code_nxt  = 2'd3;
                    state_nxt = IDLE;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 16'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            idx       <= '0;
            sum       <= '0;
            shadow    <= '0;
            timer     <= '0;
            cmd_valid <= 1'b0;
            cmd_id    <= '0;
            cmd_param <= '0;
            err_valid <= 1'b0;
            err_code  <= '0;
            ok_cnt    <= '0;
            err_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            sum       <= sum_nxt;
            shadow    <= shadow_nxt;
            timer     <= timer_nxt;
            cmd_valid <= ok_evt;
            err_valid <= err_evt;
            if (ok_evt) begin
                cmd_id    <= shadow[31:24];
                cmd_param <= shadow[23:0];
            end
            if (err_evt)
                err_code <= code_nxt;
            // Clear has priority over a coincident increment
            if (cnt_clr)
                ok_cnt <= '0;
            else if (ok_evt && ok_cnt != 16'hFFFF)
                ok_cnt <= ok_cnt + 16'd1;
            if (cnt_clr)
                err_cnt <= '0;
            else if (err_evt && err_cnt != 16'hFFFF)
                err_cnt <= err_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_hdlc_command_decode.sv
// Scoreboard bench for hdlc_command_decode: stimulus pushes expected pulses, a monitor pops them.
module tb_hdlc_command_decode;

    localparam int TO = 100;

    logic        clk = 1'b0;
    logic        rstn;
    logic        s_tvalid, s_tlast, cnt_clr;
    logic [7:0]  s_tdata;
    logic        cmd_valid, err_valid;
    logic [7:0]  cmd_id;
    logic [23:0] cmd_param;
    logic [1:0]  err_code;
    logic [15:0] ok_cnt, err_cnt;

    hdlc_command_decode #(.HEADER(8'h55), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rstn(rstn), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tdata(s_tdata),
        .cnt_clr(cnt_clr), .cmd_valid(cmd_valid), .cmd_id(cmd_id), .cmd_param(cmd_param),
        .err_valid(err_valid), .err_code(err_code), .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_err;
        logic [1:0]  code;
        logic [7:0]  id;
        logic [23:0] param;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   exp_ok = 0;
    int   exp_err = 0;

    function automatic logic [7:0] chk(input logic [7:0] b1, b2, b3, b4);
`ifdef CMD_CRC8_EN
        logic [7:0] c;
        logic [7:0] bytes [4];
        c = 8'h00;
        bytes[0] = b1; bytes[1] = b2; bytes[2] = b3; bytes[3] = b4;
        for (int k = 0; k < 4; k++) begin
            c = c ^ bytes[k];
            for (int i = 0; i < 8; i++)
                c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
        return c;
`else
        return b1 + b2 + b3 + b4;
`endif
    endfunction

    task automatic expect_cmd(input logic [7:0] id, input logic [23:0] param);
        exp_t e;
        e.is_err = 1'b0; e.code = 2'd0; e.id = id; e.param = param;
        sb.push_back(e);
        if (exp_ok != 65535) exp_ok++;
    endtask

    task automatic expect_err(input logic [1:0] code);
        exp_t e;
        e.is_err = 1'b1; e.code = code; e.id = 8'h00; e.param = 24'h0;
        sb.push_back(e);
        if (exp_err != 65535) exp_err++;
    endtask

    task automatic apply_stimulus(input logic [7:0] d, input logic last);
        s_tvalid = 1'b1;
        s_tdata  = d;
        s_tlast  = last;
        @(posedge clk);
        #1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = 8'h00;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_frame(input logic [7:0] id, input logic [23:0] p, input logic [7:0] c,
                              input logic last);
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(id, 1'b0);
        apply_stimulus(p[23:16], 1'b0);
        apply_stimulus(p[15:8], 1'b0);
        apply_stimulus(p[7:0], 1'b0);
        apply_stimulus(c, last);
    endtask

    task automatic check_counters(input string tag);
        idle(2);
        check_output({tag, "_ok_cnt"}, 32'(ok_cnt), 32'(exp_ok));
        check_output({tag, "_err_cnt"}, 32'(err_cnt), 32'(exp_err));
    endtask

    // Monitor: every output pulse must match the oldest pending expectation
    always @(negedge clk) begin
        if (rstn && (cmd_valid || err_valid)) begin
            checks++;
            if (cmd_valid && err_valid) begin
                failures++;
                $display("[TB] FAIL both_pulses: cmd_valid=1 err_valid=1 expected one");
            end else if (sb.size() == 0) begin
                failures++;
                $display("[TB] FAIL unexpected_pulse: cmd_valid=%0b err_valid=%0b code=%0d expected none",
                         cmd_valid, err_valid, err_code);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (e.is_err) begin
                    if (!err_valid || err_code !== e.code) begin
                        failures++;
                        $display("[TB] FAIL err_pulse: err_valid=%0b code=%0d expected code=%0d",
                                 err_valid, err_code, e.code);
                    end
                end else begin
                    if (!cmd_valid || cmd_id !== e.id || cmd_param !== e.param) begin
                        failures++;
                        $display("[TB] FAIL cmd_pulse: cmd_valid=%0b id=%0h param=%0h expected id=%0h param=%0h",
                                 cmd_valid, cmd_id, cmd_param, e.id, e.param);
                    end
                end
            end
        end
    end

    initial begin
        rstn = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = 8'h00; cnt_clr = 1'b0;
        #12;
        check_output("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        check_output("rst_err_valid", 32'(err_valid), 32'd0);
        check_output("rst_cmd_id", 32'(cmd_id), 32'd0);
        check_output("rst_cmd_param", 32'(cmd_param), 32'd0);
        check_output("rst_err_code", 32'(err_code), 32'd0);
        check_output("rst_ok_cnt", 32'(ok_cnt), 32'd0);
        check_output("rst_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        idle(2);

        $display("[TB] good frame");
        expect_cmd(8'h01, 24'h123456);
        send_frame(8'h01, 24'h123456, chk(8'h01, 8'h12, 8'h34, 8'h56), 1'b1);
        check_counters("good");

        $display("[TB] checksum error");
        expect_err(2'd2);
        send_frame(8'h01, 24'h123456, chk(8'h01, 8'h12, 8'h34, 8'h56) + 8'h01, 1'b1);
        check_counters("cksum");
        check_output("cksum_keep_id", 32'(cmd_id), 32'h01);
        check_output("cksum_keep_param", 32'(cmd_param), 32'h123456);
        check_output("cksum_code_held", 32'(err_code), 32'd2);

        $display("[TB] length errors");
        expect_err(2'd1);
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(8'h01, 1'b0);
        apply_stimulus(8'h12, 1'b1);
        expect_err(2'd1);
        send_frame(8'h01, 24'h123456, chk(8'h01, 8'h12, 8'h34, 8'h56), 1'b0);
        check_counters("len");

        $display("[TB] header error and recovery");
        expect_err(2'd0);
        apply_stimulus(8'hAA, 1'b0);
        expect_cmd(8'h02, 24'h000001);
        send_frame(8'h02, 24'h000001, chk(8'h02, 8'h00, 8'h00, 8'h01), 1'b1);
        check_counters("hdr");

        $display("[TB] timeout fires");
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(8'h01, 1'b0);
        idle(TO - 1);
        check_output("to_not_yet", 32'(err_valid), 32'd0);
        expect_err(2'd3);
        idle(1);
        check_counters("to");

        $display("[TB] byte wins over timeout");
        expect_cmd(8'h01, 24'h123456);
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(8'h01, 1'b0);
        idle(TO - 1);
        apply_stimulus(8'h12, 1'b0);
        apply_stimulus(8'h34, 1'b0);
        apply_stimulus(8'h56, 1'b0);
        apply_stimulus(chk(8'h01, 8'h12, 8'h34, 8'h56), 1'b1);
        check_counters("to_win");

        $display("[TB] reset mid-frame");
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(8'h07, 1'b0);
        rstn = 1'b0;
        #2;
        check_output("midrst_ok_cnt", 32'(ok_cnt), 32'd0);
        @(posedge clk); #1;
        rstn = 1'b1;
        exp_ok = 0;
        exp_err = 0;
        expect_cmd(8'h03, 24'hA0B0C0);
        send_frame(8'h03, 24'hA0B0C0, chk(8'h03, 8'hA0, 8'hB0, 8'hC0), 1'b1);
        check_counters("midrst");

        $display("[TB] clear coincides with increment");
        expect_cmd(8'h04, 24'h010203);
        apply_stimulus(8'h55, 1'b0);
        apply_stimulus(8'h04, 1'b0);
        apply_stimulus(8'h01, 1'b0);
        apply_stimulus(8'h02, 1'b0);
        apply_stimulus(8'h03, 1'b0);
        cnt_clr = 1'b1;
        apply_stimulus(chk(8'h04, 8'h01, 8'h02, 8'h03), 1'b1);
        cnt_clr = 1'b0;
        exp_ok = 0;
        exp_err = 0;
        check_counters("clr");

        $display("[TB] error counter saturation");
        for (int i = 0; i < 65535; i++) begin
            expect_err(2'd0);
            apply_stimulus(8'h00, 1'b0);
        end
        check_counters("sat_reach");
        expect_err(2'd0);
        apply_stimulus(8'h13, 1'b1);
        check_counters("sat_hold");
        check_output("sat_value", 32'(err_cnt), 32'h0000FFFF);

        idle(5);
        check_output("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
